oldland_mem_arbiter: RTL
========================

# oldland_mem_arbiter

Two-master to one-slave memory bus arbiter that shares a single external memory port between the instruction-cache refill bus and the data-cache refill/writeback bus of the CPU. It sits between the cache memory-side ports (`i_*` / `d_*`) and the SoC memory interconnect. Arbitration is round-robin; the winning request is latched for the duration of one transfer. An optional watchdog terminates slave transactions that never respond.

## Interface
- `timeout_cycles`, default 255. Maximum cycles `m_access` stays high before a timeout error; only used with `OLDLAND_ARB_TIMEOUT_EN`; legal range 2..65535.
- `clk` in 1: sole clock; all state changes on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `i_access` in 1: instruction master request; held until `i_ack`/`i_error`.
- `i_addr` in 30: instruction word address.
- `i_data` out 32: read data; equals `m_data`; valid only while `i_ack`.
- `i_ack` out 1: instruction transfer complete (one-cycle pulse).
- `i_error` out 1: instruction transfer failed (one-cycle pulse).
- `d_access` in 1: data master request; held until `d_ack`/`d_error`.
- `d_addr` in 30: data word address.
- `d_bytesel` in 4: data byte enables.
- `d_wr_en` in 1: data write.
- `d_wr_val` in 32: data write value.
- `d_data` out 32: read data; equals `m_data`; valid only while `d_ack`.
- `d_ack` out 1: data transfer complete (one-cycle pulse).
- `d_error` out 1: data transfer failed (one-cycle pulse).
- `m_access` out 1: slave request.
- `m_addr` out 30: slave word address.
- `m_bytesel` out 4: slave byte enables.
- `m_wr_en` out 1: slave write.
- `m_wr_val` out 32: slave write data.
- `m_data` in 32: slave read data.
- `m_ack` in 1: slave completion.
- `m_error` in 1: slave error completion.
- `busy` out 1: high whenever a grant is active.

## Operation
- States:
  - IDLE
  - GRANT_I
  - GRANT_D
- Round-robin pointer `last_d`. It is 1 after reset, so the instruction master wins the first tie.
- IDLE transitions:
  - Only `i_access` high: go to GRANT_I.
  - Only `d_access` high: go to GRANT_D.
  - Both high: grant the master that is not `last_d`'s owner, i.e. I if `last_d`=1, else D.
  - Neither high: stay in IDLE.
- On the grant edge, register the winning master's request onto the slave port:
  - `m_addr`, `m_bytesel`, `m_wr_en` and `m_wr_val` are latched.
  - `m_access` is set to 1.
  - `last_d` is updated.
  - An instruction grant always drives `m_wr_en`=0, `m_bytesel`=4'b1111 and `m_wr_val`=0.
- Slave outputs hold constant for the whole grant. Deasserting the master's `*_access` mid-grant has no effect; the completion pulse is still delivered.
- In GRANT_x, `m_ack` or `m_error` is forwarded combinationally to the owning master's `*_ack` / `*_error` in the same cycle. On that edge the arbiter returns to IDLE and clears `m_access`.
- `m_ack` and `m_error` both high: `m_error` wins; the ack is suppressed.
- `m_ack` / `m_error` arriving in IDLE are ignored.
- The non-owning master's ack and error outputs are always 0.
- `i_data` and `d_data` are continuous copies of `m_data`.

## Timing
- Reset values:
  - `m_access`, `m_wr_en`, `busy`, `i_ack`, `i_error`, `d_ack`, `d_error` = 0.
  - `m_addr`, `m_bytesel`, `m_wr_val` = 0.
  - State = IDLE; `last_d` = 1.
- Request latency: a master request sampled in cycle N gives `m_access`=1 in cycle N+1.
- Response latency: zero cycles from `m_ack`/`m_error` to the master.
- Every transfer includes one IDLE cycle after completion, so back-to-back transfers are spaced by at least 1 idle cycle on `m_access`.
- `busy` equals `m_access`.
- Reset mid-transfer: at the edge where `rst` is sampled high, the grant is abandoned. `m_access` is 0 from the next cycle and no ack/error is delivered for the abandoned transfer. Masters reissue their requests.
- `rst` overrides all other events in the same cycle.

## Configuration
- `OLDLAND_ARB_TIMEOUT_EN` defined:
  - A 16-bit counter clears on each grant edge and increments every GRANT cycle without `m_ack`/`m_error`.
  - In the cycle where the counter equals `timeout_cycles-1` with no slave response, the owner's `*_error` pulses and the state returns to IDLE.
  - `m_access` is therefore high for exactly `timeout_cycles` cycles.
  - A slave response in that same cycle takes priority over the timeout.
- `OLDLAND_ARB_TIMEOUT_EN` undefined:
  - No counter is built; a grant persists until the slave responds.
  - `timeout_cycles` is ignored.

## Test plan
- I read: `i_access`=1, `i_addr`=30'h100; slave acks with `m_data`=32'hdeadbeef 2 cycles after `m_access` -> `m_addr`=30'h100, `m_wr_en`=0, `m_bytesel`=4'b1111; `i_ack` 1 cycle with `i_data`=32'hdeadbeef; `d_ack` never asserts.
- D write: `d_addr`=30'h2000, `d_bytesel`=4'b0011, `d_wr_val`=32'h1234, `d_wr_en`=1; slave acks after 1 cycle -> slave port carries exactly these values, `d_ack` pulses once, then `m_access`=0 for ≥1 cycle.
- Fairness: both masters request continuously from reset; each transfer acked after 1 cycle -> grant order I,D,I,D, and no master is granted twice in a row.
- Error: D read with slave `m_error`=1 and `m_ack`=1 together -> `d_error` pulses, `d_ack` stays 0, state returns to IDLE.
- Timeout: with macro defined, `timeout_cycles`=4 and a silent slave on an I read -> `m_access` high 4 cycles, `i_error` in the 4th, then a pending D request is granted. Without the macro -> `m_access` is still high after 100 cycles.
- Reset mid-op: `rst` pulsed in the 2nd GRANT_D cycle -> `m_access`=0 next cycle, no `d_ack`/`d_error`; a subsequent simultaneous I+D request grants I first.

Source files
------------

// File: rtl/oldland_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the I-cache and D-cache refill buses.
// Optional slave watchdog is built when OLDLAND_ARB_TIMEOUT_EN is defined.
module oldland_mem_arbiter #(
    parameter int timeout_cycles = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        i_access,
    input  logic [29:0] i_addr,
    output logic [31:0] i_data,
    output logic        i_ack,
    output logic        i_error,

    input  logic        d_access,
    input  logic [29:0] d_addr,
    input  logic [3:0]  d_bytesel,
    input  logic        d_wr_en,
    input  logic [31:0] d_wr_val,
    output logic [31:0] d_data,
    output logic        d_ack,
    output logic        d_error,

    output logic        m_access,
    output logic [29:0] m_addr,
    output logic [3:0]  m_bytesel,
    output logic        m_wr_en,
    output logic [31:0] m_wr_val,
    input  logic [31:0] m_data,
    input  logic        m_ack,
    input  logic        m_error,

    output logic        busy,
    output logic [1:0]  dbg_state
);

    // Handshake: a master holds *_access until it sees its one-cycle *_ack or
    // *_error; the slave sees m_access held until it answers with m_ack/m_error.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    state_t      state_q;
    logic        last_d_q;
    logic        m_access_q;
    logic [29:0] m_addr_q;
    logic [3:0]  m_bytesel_q;
    logic        m_wr_en_q;
    logic [31:0] m_wr_val_q;

    logic        grant_i_d;
    logic        grant_d_d;
    logic        slave_done_d;
    logic        timeout_hit_d;
    logic        xfer_done_d;
    logic        ack_d;
    logic        err_d;

    // On a tie the master that was not served last wins.
    assign grant_i_d    = i_access & (~d_access | last_d_q);
    assign grant_d_d    = d_access & (~i_access | ~last_d_q);
    assign slave_done_d = m_ack | m_error;

`ifdef OLDLAND_ARB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(timeout_cycles - 1);
    logic [15:0] timer_q;

    assign timeout_hit_d = (state_q != IDLE) & ~slave_done_d & (timer_q == TIMEOUT_LAST);
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^32'(timeout_cycles);
    assign timeout_hit_d      = 1'b0;
`endif

    assign xfer_done_d = (state_q != IDLE) & (slave_done_d | timeout_hit_d);
    assign ack_d       = m_ack & ~m_error;
    assign err_d       = m_error | timeout_hit_d;

    // Responses are forwarded combinationally; reset suppresses them so an
    // abandoned transfer never completes.
    assign i_ack   = ~rst & (state_q == GRANT_I) & ack_d;
    assign i_error = ~rst & (state_q == GRANT_I) & err_d;
    assign d_ack   = ~rst & (state_q == GRANT_D) & ack_d;
    assign d_error = ~rst & (state_q == GRANT_D) & err_d;

    assign i_data    = m_data;
    assign d_data    = m_data;
    assign m_access  = m_access_q;
    assign m_addr    = m_addr_q;
    assign m_bytesel = m_bytesel_q;
    assign m_wr_en   = m_wr_en_q;
    assign m_wr_val  = m_wr_val_q;
    assign busy      = m_access_q;
    assign dbg_state = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_d_q    <= 1'b1;
            m_access_q  <= 1'b0;
            m_addr_q    <= 30'd0;
            m_bytesel_q <= 4'd0;
            m_wr_en_q   <= 1'b0;
            m_wr_val_q  <= 32'd0;
`ifdef OLDLAND_ARB_TIMEOUT_EN
            timer_q     <= 16'd0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_i_d) begin
                        state_q     <= GRANT_I;
                        last_d_q    <= 1'b0;
                        m_access_q  <= 1'b1;
                        m_addr_q    <= i_addr;
                        m_bytesel_q <= 4'b1111;
                        m_wr_en_q   <= 1'b0;
                        m_wr_val_q  <= 32'd0;
                    end else if (grant_d_d) begin
                        state_q     <= GRANT_D;
                        last_d_q    <= 1'b1;
                        m_access_q  <= 1'b1;
                        m_addr_q    <= d_addr;
                        m_bytesel_q <= d_bytesel;
                        m_wr_en_q   <= d_wr_en;
                        m_wr_val_q  <= d_wr_val;
                    end
`ifdef OLDLAND_ARB_TIMEOUT_EN
                    timer_q <= 16'd0;
`endif
                end
                GRANT_I, GRANT_D: begin
                    // The completion edge always drops back to IDLE, giving one idle cycle.
                    if (xfer_done_d) begin
                        state_q    <= IDLE;
                        m_access_q <= 1'b0;
                    end
`ifdef OLDLAND_ARB_TIMEOUT_EN
                    else begin
                        timer_q <= timer_q + 16'd1;
                    end
`endif
                end
                default: begin
                    state_q    <= IDLE;
                    m_access_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
